aes_decryption: RTL and testbench
=================================

Name: aes_decryption

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); the decrypt-side counterpart of the team's AES-128 encryption core.
- One round per clock. Round keys are generated on the fly: forward expansion to round key 10, then inverse expansion back to round key 0 during decryption.
- S-boxes sit outside the block, matching the encryption core's partitioning:
  - 128-bit inverse S-box on the state path.
  - 32-bit forward S-box on the key path.
- Sits beside the encryption core in the AES top; driven by a start/done handshake.

Parameters:
- None. Widths are fixed by AES-128: 128-bit text/key, 32-bit key word, 4-bit round counter.

Ports:
- clk_i  input  1  Clock; all registers on the rising edge.
- rst_ni  input  1  Reset. Asynchronous, active-low.
- start_i  input  1  Start request; sampled only in IDLE.
- ciphertext_i  input  128  Ciphertext; captured on the edge that accepts start_i.
- key_i  input  128  Cipher key (round key 0); captured with ciphertext_i.
- inv_sbox_o  output  128  InvShiftRows(state_reg), sent to the external inverse S-box.
- inv_sbox_i  input  128  InvSubBytes(inv_sbox_o); combinational return, same cycle.
- key_sbox_o  output  32  Key word sent to the external forward S-box.
- key_sbox_i  input  32  SubWord(key_sbox_o); combinational return, same cycle.
- busy_o  output  1  High while a block is in progress.
- done_o  output  1  One-cycle pulse; plaintext_o is valid from this cycle.
- plaintext_o  output  128  Result register. Holds until the next completion.

Behaviour:
- Byte order: bits [127:120] = byte 0 = s[0,0], column-major (FIPS-197). Word w0 = bits [127:96].
- Reset (async, rst_ni=0): FSM=IDLE, counter=0. state_reg, key_reg, plaintext_o = 0. busy_o = done_o = 0. Reset mid-operation aborts the block; no done_o is produced.
- FSM states: IDLE -> KEYEXP -> ADDKEY -> ROUND -> IDLE.
- IDLE:
  - start_i=1 loads state_reg=ciphertext_i, key_reg=key_i, rnd=1; go to KEYEXP.
  - start_i is ignored in every other state; there is no queueing.
- KEYEXP (10 cycles, rnd 1..10):
  - key_sbox_o = RotWord(w3).
  - Update: t = key_sbox_i ^ {Rcon[rnd],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - After rnd=10: key_reg = rk10; go to ADDKEY.
- ADDKEY (1 cycle): state_reg ^= key_reg. Set rnd=9; go to ROUND.
- ROUND (10 cycles, rnd 9..0):
  - Previous round key, combinational:
    - v3=w3^w2, v2=w2^w1, v1=w1^w0.
    - key_sbox_o = RotWord(v3).
    - v0 = w0 ^ key_sbox_i ^ {Rcon[rnd+1],24'h0}.
    - rk_rnd = {v0,v1,v2,v3}.
  - Datapath: x = inv_sbox_i ^ rk_rnd.
    - rnd!=0: state_reg = InvMixColumns(x); key_reg = rk_rnd; rnd decrements.
    - rnd=0: plaintext_o = x; done_o=1 next cycle; go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Index 0 is unused.
- key_sbox_o and inv_sbox_o are don't-care in IDLE and ADDKEY, but must be stable (no X) after reset.
- Latency: done_o is high in the cycle after the 21st edge following the accepting edge.
  - Back-to-back: start_i held high starts the next block in the cycle done_o is high (done cycle is IDLE).
  - Throughput: 22 cycles per block.
- busy_o = (FSM != IDLE).
- done_o is a single pulse and is registered.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext_o 00112233445566778899aabbccddeeff; done_o exactly 21 cycles after the start edge, 1 cycle wide.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Probe key_reg = d014f9a8c9ee2589e13f0cc8b6630ca6 at ADDKEY.
- Start pulses during busy, and ciphertext_i/key_i changed mid-block -> ignored; the C.1 result is unchanged.
- start_i held high continuously with alternating C.1 and App B vectors -> correct results, done_o every 22 cycles.
- rst_ni low at round 5, then a new C.1 start -> no done_o for the aborted block; all outputs 0 during reset; next result correct.
- Randomised: 200 random key/plaintext pairs, encrypted by the reference encryption core or a model -> aes_decryption returns the original plaintext. The bench models both S-boxes combinationally.

Source files
------------

// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-the-fly round keys.
// Both S-boxes live outside this block and answer combinationally in the same cycle.
module aes_decryption (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] key_i,
  output logic [127:0] inv_sbox_o,
  input  logic [127:0] inv_sbox_i,
  output logic [31:0]  key_sbox_o,
  input  logic [31:0]  key_sbox_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] plaintext_o
);

  typedef enum logic [1:0] {StIdle, StKeyExp, StAddKey, StRound} state_e;

  state_e       r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_data;
  logic [127:0] r_key;
  logic [127:0] r_pt;
  logic         r_done;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    inv_mix_col = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                   m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                   m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                   m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4], byte index 4c + r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_v0, w_v1, w_v2, w_v3;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_key_fwd;
  logic [127:0] w_rk_prev;
  logic [127:0] w_x;
  logic [127:0] w_imc;
  logic         w_in_round;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_in_round = (r_fsm == StRound);

  // Forward expansion step (KEYEXP)
  assign w_t       = key_sbox_i ^ {rcon(r_rnd), 24'h0};
  assign w_n0      = w_w0 ^ w_t;
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_key_fwd = {w_n0, w_n1, w_n2, w_n3};

  // Inverse expansion step (ROUND): recovers round key rnd from round key rnd+1
  assign w_v3      = w_w3 ^ w_w2;
  assign w_v2      = w_w2 ^ w_w1;
  assign w_v1      = w_w1 ^ w_w0;
  assign w_v0      = w_w0 ^ key_sbox_i ^ {rcon(r_rnd + 4'd1), 24'h0};
  assign w_rk_prev = {w_v0, w_v1, w_v2, w_v3};

  assign key_sbox_o = w_in_round ? {w_v3[23:0], w_v3[31:24]} : {w_w3[23:0], w_w3[31:24]};
  assign inv_sbox_o = inv_shift_rows(r_data);

  assign w_x   = inv_sbox_i ^ w_rk_prev;
  assign w_imc = inv_mix_columns(w_x);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm  <= StIdle;
      r_rnd  <= 4'd0;
      r_data <= '0;
      r_key  <= '0;
      r_pt   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        StIdle: begin
          if (start_i) begin
            r_data <= ciphertext_i;
            r_key  <= key_i;
            r_rnd  <= 4'd1;
            r_fsm  <= StKeyExp;
          end
        end
        StKeyExp: begin
          r_key <= w_key_fwd;
          if (r_rnd == 4'd10) begin
            r_fsm <= StAddKey;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        StAddKey: begin
          r_data <= r_data ^ r_key;
          r_rnd  <= 4'd9;
          r_fsm  <= StRound;
        end
        StRound: begin
          if (r_rnd == 4'd0) begin
            r_pt   <= w_x;
            r_done <= 1'b1;
            r_fsm  <= StIdle;
          end else begin
            r_data <= w_imc;
            r_key  <= w_rk_prev;
            r_rnd  <= r_rnd - 4'd1;
          end
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign busy_o      = (r_fsm != StIdle);
  assign done_o      = r_done;
  assign plaintext_o = r_pt;

endmodule

// File: tb/tb_aes_decryption.sv
// Directed and randomised bench for aes_decryption; S-boxes and a forward cipher are
// modelled arithmetically (GF(2^8) inverse plus affine map) rather than by table.
module tb_aes_decryption;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic [127:0] isb_out;
  logic [127:0] isb_in;
  logic [31:0]  ksb_out;
  logic [31:0]  ksb_in;
  logic         busy;
  logic         done;
  logic [127:0] pt_out;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  aes_decryption dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .ciphertext_i (ct_in),
    .key_i        (key_in),
    .inv_sbox_o   (isb_out),
    .inv_sbox_i   (isb_in),
    .key_sbox_o   (ksb_out),
    .key_sbox_i   (ksb_in),
    .busy_o       (busy),
    .done_o       (done),
    .plaintext_o  (pt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, base;
    logic [7:0] e;
    r = 8'h01; base = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_tb(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return rc;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t, rk;
    logic [31:0]  w0, w1, w2, w3, tmp;
    rk = key;
    s  = pt ^ rk;
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      t = s;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
      if (rd != 10)
        for (int c = 0; c < 4; c++) s[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      {w0, w1, w2, w3} = rk;
      tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_tb(rd), 24'h0};
      w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk = {w0, w1, w2, w3};
      s  = s ^ rk;
    end
    return s;
  endfunction

  always_comb begin
    isb_in = '0;
    for (int i = 0; i < 16; i++) isb_in[127-8*i -: 8] = inv_sbox(isb_out[127-8*i -: 8]);
  end
  assign ksb_in = sub_word(ksb_out);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] ct, input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    ct_in  = ct;
    key_in = key;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] exp_pt, input bit chk_lat);
    int unsigned t0;
    bit seen;
    start_block(ct, key);
    t0 = cyc;
    wait_done(40, seen);
    check({tag, "_done_seen"}, seen, 1'b1);
    if (chk_lat) check({tag, "_latency"}, cyc - t0, 21);
    check({tag, "_pt"}, pt_out, exp_pt);
  endtask

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] vct [2];
    logic [127:0] vkey [2];
    logic [127:0] vpt [2];
    logic [127:0] rk, rp, rc;
    int unsigned t0, tprev, ndone;
    bit seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    ct_in  = '0;
    key_in = '0;

    // Reset state
    #1;
    check("rst_pt", pt_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_isb", isb_out, '0);
    check("rst_ksb", ksb_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 C.1 with latency and single-cycle done
    run_block("c1", C1Ct, C1Key, C1Pt, 1'b1);
    @(posedge clk);
    #1;
    check("c1_done_width", done, 1'b0);
    check("c1_idle", busy, 1'b0);
    check("c1_pt_hold", pt_out, C1Pt);

    // App B, probing the fully expanded key at ADDKEY
    start_block(BCt, BKey);
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    check("b_rk10", dut.r_key, BRk10);
    check("b_busy", busy, 1'b1);
    wait_done(40, seen);
    check("b_done_seen", seen, 1'b1);
    check("b_latency", cyc - t0, 21);
    check("b_pt", pt_out, BPt);

    // Start pulses and input changes mid-block are ignored
    start_block(C1Ct, C1Key);
    t0 = cyc;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    ct_in  = BCt;
    key_in = BKey;
    repeat (5) begin
      @(negedge clk);
      ct_in  = {$urandom, $urandom, $urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b0;
    wait_done(40, seen);
    check("ign_done_seen", seen, 1'b1);
    check("ign_latency", cyc - t0, 21);
    check("ign_pt", pt_out, C1Pt);

    // Back-to-back with start held high, alternating vectors
    vct[0] = C1Ct; vkey[0] = C1Key; vpt[0] = C1Pt;
    vct[1] = BCt;  vkey[1] = BKey;  vpt[1] = BPt;
    @(negedge clk);
    start  = 1'b1;
    ct_in  = vct[0];
    key_in = vkey[0];
    @(posedge clk);
    #1;
    t0 = cyc;
    tprev = t0;
    for (int i = 0; i < 4; i++) begin
      ct_in  = vct[(i+1)%2];
      key_in = vkey[(i+1)%2];
      wait_done(30, seen);
      check($sformatf("b2b%0d_done_seen", i), seen, 1'b1);
      check($sformatf("b2b%0d_pt", i), pt_out, vpt[i%2]);
      check($sformatf("b2b%0d_interval", i), cyc - tprev, (i == 0) ? 21 : 22);
      tprev = cyc;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    // Reset during round 5 aborts the block
    start_block(C1Ct, C1Key);
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pt", pt_out, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_isb", isb_out, '0);
    check("abort_ksb", ksb_out, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_block("post_abort", C1Ct, C1Key, C1Pt, 1'b1);

    // Random round trips through the forward cipher model
    for (int i = 0; i < 200; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = aes_encrypt(rp, rk);
      run_block($sformatf("rnd%0d", i), rc, rk, rp, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
